// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_WIDTH bits LSB-first, optional parity, STOP_BITS stop bits; optional UART_TX_PARITY_INJ_EN.
// Latency: start bit on the line from the acceptance edge; frame is CLKS_PER_BIT*(1+DATA_WIDTH+P+STOP_BITS) cycles.
// Backpressure: tx_ready high only in IDLE; tx_valid is ignored while a frame is on the line.
module uart_tx_frame #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic [1:0]            parity_mode,
    input  logic                  tx_valid,
`ifdef UART_TX_PARITY_INJ_EN
    input  logic                  parity_inject,
`endif
    output logic                  tx_ready,
    output logic                  tx_serial,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                state_q, state_nxt;
    logic [BW-1:0]         baud_q, baud_nxt;
    logic [IW-1:0]         bit_q, bit_nxt;
    logic [DATA_WIDTH-1:0] sh_q, sh_nxt;
    logic                  par_q, par_nxt;
    logic                  par_en_q, par_en_nxt;
    logic                  serial_nxt, busy_nxt, done_nxt;
    logic                  accept, wrap, par_calc, par_en_calc, inj;

`ifdef UART_TX_PARITY_INJ_EN
    assign inj = parity_inject;
`else
    assign inj = 1'b0;
`endif

    assign tx_ready    = (state_q == S_IDLE);
    assign accept      = tx_valid && tx_ready;
    assign wrap        = (baud_q == BAUD_LAST);
    assign par_en_calc = (parity_mode == 2'b01) || (parity_mode == 2'b10);
    assign par_calc    = (parity_mode == 2'b01) ? ^tx_data : ~^tx_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            par_q     <= 1'b0;
            par_en_q  <= 1'b0;
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            baud_q    <= baud_nxt;
            bit_q     <= bit_nxt;
            sh_q      <= sh_nxt;
            par_q     <= par_nxt;
            par_en_q  <= par_en_nxt;
            tx_serial <= serial_nxt;
            tx_busy   <= busy_nxt;
            tx_done   <= done_nxt;
        end
    end

    // The data word is shifted right as each bit completes, so the line always shows sh_q[0] in DATA.
    always_comb begin
        state_nxt  = state_q;
        baud_nxt   = wrap ? '0 : baud_q + BW'(1);
        bit_nxt    = bit_q;
        sh_nxt     = sh_q;
        par_nxt    = par_q;
        par_en_nxt = par_en_q;
        case (state_q)
            S_IDLE: begin
                baud_nxt = '0;
                bit_nxt  = '0;
                if (accept) begin
                    state_nxt  = S_START;
                    sh_nxt     = tx_data;
                    par_nxt    = par_calc ^ inj;
                    par_en_nxt = par_en_calc;
                end
            end
            S_START: begin
                if (wrap) begin
                    state_nxt = S_DATA;
                    bit_nxt   = '0;
                end
            end
            S_DATA: begin
                if (wrap) begin
                    sh_nxt = sh_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        state_nxt = par_en_q ? S_PARITY : S_STOP;
                        bit_nxt   = '0;
                    end else begin
                        bit_nxt = bit_q + IW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (wrap) begin
                    state_nxt = S_STOP;
                    bit_nxt   = '0;
                end
            end
            S_STOP: begin
                if (wrap) begin
                    if (bit_q == STOP_LAST) begin
                        state_nxt = S_IDLE;
                        bit_nxt   = '0;
                    end else begin
                        bit_nxt = bit_q + IW'(1);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state and registered, so the line changes on the advancing edge.
    always_comb begin
        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_q == S_STOP) && (state_nxt == S_IDLE);
        case (state_nxt)
            S_START:  serial_nxt = 1'b0;
            S_DATA:   serial_nxt = sh_nxt[0];
            S_PARITY: serial_nxt = par_q;
            default:  serial_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboarded bench for uart_tx_frame: an 8-bit/1-stop and a 7-bit/2-stop instance, both at 4 clocks per bit.
module tb_uart_tx_frame;
    localparam int CPB = 4;

    typedef struct {
        string f;
        int    gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d8;
    logic [6:0] d7;
    logic [1:0] mode;
    logic       v8, v7, pinj, sel, mon_en, mon_busy;
    logic       r8, s8, b8, dn8, r7, s7, b7, dn7;
    logic       line, busy, done, rdy;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         last_done;
    exp_t       exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign line = sel ? s7 : s8;
    assign busy = sel ? b7 : b8;
    assign done = sel ? dn7 : dn8;
    assign rdy  = sel ? r7 : r8;

    uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) u8 (
        .clk(clk), .rst_n(rst_n), .tx_data(d8), .parity_mode(mode), .tx_valid(v8),
`ifdef UART_TX_PARITY_INJ_EN
        .parity_inject(pinj),
`endif
        .tx_ready(r8), .tx_serial(s8), .tx_busy(b8), .tx_done(dn8)
    );

    uart_tx_frame #(.DATA_WIDTH(7), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) u7 (
        .clk(clk), .rst_n(rst_n), .tx_data(d7), .parity_mode(mode), .tx_valid(v7),
`ifdef UART_TX_PARITY_INJ_EN
        .parity_inject(pinj),
`endif
        .tx_ready(r7), .tx_serial(s7), .tx_busy(b7), .tx_done(dn7)
    );

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic chk_s(input string name, input string act, input string expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %s expected %s (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic expect_frame(input string f, input int gap);
        exp_t e;
        e.f = f;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic s, input logic [7:0] d, input logic [1:0] m, input logic inj);
        int t;
        t = 0;
        sel = s;
        @(negedge clk);
        while (!rdy && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!rdy) chk("ready_timeout", 0, 1);
        d8 = d;
        d7 = d[6:0];
        mode = m;
        pinj = inj;
        v8 = !s;
        v7 = s;
        @(posedge clk);
        #1;
        v8 = 1'b0;
        v7 = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        bit ok;
        ok = 1'b0;
        for (t = 0; t < 400 && !ok; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mon_busy && !b8 && !b7) ok = 1'b1;
        end
        chk("drain", int'(ok), 1);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: on a start bit, pop the expected frame and compare every sampled cycle.
    initial begin : monitor
        exp_t  e;
        string got;
        bit    stable;
        logic  bv;
        int    n;
        last_done = -100;
        mon_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (line === 1'b0 && busy && mon_en) begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    e.f = "0000000000";
                    e.gap = -1;
                end else begin
                    e = exp_q.pop_front();
                end
                if (e.gap >= 0) chk("b2b_gap", cyc - last_done, e.gap);
                n = e.f.len();
                got = "";
                stable = 1'b1;
                bv = 1'b0;
                for (int b = 0; b < n; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (c == 0) begin
                            bv = line;
                            got = {got, (line === 1'b1) ? "1" : "0"};
                        end else if (line !== bv) begin
                            stable = 1'b0;
                        end
                        if (done) stable = 1'b0;
                    end
                end
                @(negedge clk);
                chk_s("frame_bits", got, e.f);
                chk("bit_hold", int'(stable), 1);
                chk("done_pulse", int'(done), 1);
                chk("busy_after", int'(busy), 0);
                last_done = cyc;
                mon_busy = 1'b0;
            end else if (done === 1'b1) begin
                chk("spurious_done", 1, 0);
            end
        end
    end

    initial begin : stim
        bit saw;
        int t;
        rst_n = 1'b1;
        d8 = '0; d7 = '0; mode = 2'b00; v8 = 1'b0; v7 = 1'b0; pinj = 1'b0;
        sel = 1'b0; mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_serial", int'(s8), 1);
        chk("rst_ready", int'(r8), 1);
        chk("rst_busy", int'(b8), 0);
        chk("rst_done", int'(dn8), 0);
        chk("rst_serial7", int'(s7), 1);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Abort mid-DATA: the line must go high at once and no tx_done may follow.
        send(1'b0, 8'hAA, 2'b00, 1'b0);
        repeat (20) @(negedge clk);
        chk("pre_abort_busy", int'(b8), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_serial", int'(s8), 1);
        chk("abort_busy", int'(b8), 0);
        chk("abort_ready", int'(r8), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (60) begin
            @(negedge clk);
            saw |= dn8;
        end
        chk("abort_no_done", int'(saw), 0);
        mon_en = 1'b1;

        expect_frame("0101001011", -1);
        send(1'b0, 8'hA5, 2'b00, 1'b0);
        wait_idle();
        expect_frame("00101010101", -1);
        send(1'b0, 8'hAA, 2'b01, 1'b0);
        wait_idle();
        expect_frame("01111101111", -1);
        send(1'b0, 8'hDF, 2'b01, 1'b0);
        wait_idle();
        expect_frame("01111111111", -1);
        send(1'b0, 8'hFF, 2'b10, 1'b0);
        wait_idle();
        expect_frame("00011001111", -1);
        send(1'b0, 8'hCC, 2'b10, 1'b0);
        wait_idle();
        expect_frame("0010110101", -1);
        send(1'b0, 8'h5A, 2'b11, 1'b0);
        wait_idle();

        expect_frame("01000001011", -1);
        send(1'b1, 8'h41, 2'b01, 1'b0);
        wait_idle();
        sel = 1'b0;

        // Back-to-back with tx_valid held; data/mode churn mid-frame must not leak into frame 1.
        expect_frame("0100000001", -1);
        expect_frame("0000000011", 1);
        @(negedge clk);
        d8 = 8'h01; mode = 2'b00; v8 = 1'b1;
        @(posedge clk);
        #1 d8 = 8'h80;
        repeat (10) @(negedge clk);
        v8 = 1'b0;
        @(negedge clk);
        v8 = 1'b1; d8 = 8'hFF; mode = 2'b01;
        @(negedge clk);
        d8 = 8'h80; mode = 2'b00;
        t = 0;
        @(negedge clk);
        while (!dn8 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("b2b_done_seen", int'(dn8), 1);
        @(posedge clk);
        #1 v8 = 1'b0;
        wait_idle();

`ifdef UART_TX_PARITY_INJ_EN
        expect_frame("00101010111", -1);
        send(1'b0, 8'hAA, 2'b01, 1'b1);
        wait_idle();
        expect_frame("0010101011", -1);
        send(1'b0, 8'hAA, 2'b00, 1'b1);
        wait_idle();
`endif

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
